// File: rtl/siphash_pkg.sv
// ============================================================================
// Module : siphash_pkg
// Brief  : Shared SipHash constants and feeder state encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package siphash_pkg;

  localparam logic [63:0] SIP_IV0 = 64'h736f6d6570736575;
  localparam logic [63:0] SIP_IV1 = 64'h646f72616e646f6d;
  localparam logic [63:0] SIP_IV2 = 64'h6c7967656e657261;
  localparam logic [63:0] SIP_IV3 = 64'h7465646279746573;

  localparam logic [3:0] DEFAULT_C_ROUNDS = 4'd2;
  localparam logic [3:0] DEFAULT_D_ROUNDS = 4'd4;

  // The final word carries the message length in its top byte lane.
  localparam int unsigned LEN_LANE = 7;
  localparam int unsigned LEN_LSB  = LEN_LANE * 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ACC   = 3'd2,
    ST_COMP  = 3'd3,
    ST_CWAIT = 3'd4,
    ST_PADW  = 3'd5,
    ST_FIN   = 3'd6,
    ST_FWAIT = 3'd7
  } feeder_state_t;

endpackage

`default_nettype wire

// File: rtl/siphash_msg_feeder_if.sv
// ============================================================================
// Module : siphash_msg_feeder_if
// Brief  : Byte-stream valid/ready bundle between a host and the feeder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface siphash_msg_feeder_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_empty;

  modport master (output s_valid, output s_data, output s_last, output s_empty,
                  input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_last, input  s_empty,
                  output s_ready);
endinterface

`default_nettype wire

// File: rtl/siphash_msg_feeder.sv
// ============================================================================
// Module : siphash_msg_feeder
// Brief  : Packs a byte stream into 64-bit words, pads and drives siphash_core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module siphash_msg_feeder
  import siphash_pkg::*;
#(
  parameter logic [3:0] C_ROUNDS = DEFAULT_C_ROUNDS,
  parameter logic [3:0] D_ROUNDS = DEFAULT_D_ROUNDS
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic [127:0]      key,
  siphash_msg_feeder_if.slave    s,
  output logic                   core_initalize,
  output logic                   core_compress,
  output logic                   core_finalize,
  output logic                   core_long,
  output logic [3:0]             core_c,
  output logic [3:0]             core_d,
  output logic [127:0]           core_k,
  output logic [63:0]            core_mi,
  input  wire logic              core_ready,
  input  wire logic [63:0]       core_word,
  input  wire logic              core_word_valid,
  output logic [63:0]            digest,
  output logic                   digest_valid
);

  feeder_state_t r_state;
  logic [2:0]    r_idx;
  logic [7:0]    r_len;
  logic          r_pad_pending;
  logic          r_final_pending;

  logic          w_accept;
  logic          w_has_byte;
  logic [7:0]    w_len_next;

  assign core_long  = 1'b0;
  assign core_c     = C_ROUNDS;
  assign core_d     = D_ROUNDS;

  assign w_accept   = s.s_valid && s.s_ready;
  assign w_has_byte = !(s.s_last && s.s_empty);
  assign w_len_next = r_len + {7'd0, w_has_byte};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_idx           <= 3'd0;
      r_len           <= 8'd0;
      r_pad_pending   <= 1'b0;
      r_final_pending <= 1'b0;
      s.s_ready       <= 1'b0;
      core_initalize  <= 1'b0;
      core_compress   <= 1'b0;
      core_finalize   <= 1'b0;
      core_k          <= 128'd0;
      core_mi         <= 64'd0;
      digest          <= 64'd0;
      digest_valid    <= 1'b0;
    end else begin
      core_initalize <= 1'b0;
      core_compress  <= 1'b0;
      core_finalize  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (s.s_valid && core_ready) begin
            core_k          <= key;
            r_idx           <= 3'd0;
            r_len           <= 8'd0;
            r_pad_pending   <= 1'b0;
            r_final_pending <= 1'b0;
            digest_valid    <= 1'b0;
            core_initalize  <= 1'b1;
            r_state         <= ST_INIT;
          end
        end
        ST_INIT: begin
          core_mi   <= 64'd0;
          s.s_ready <= 1'b1;
          r_state   <= ST_ACC;
        end
        ST_ACC: begin
          if (w_accept) begin
            if (w_has_byte) begin
              core_mi[{r_idx, 3'b000} +: 8] <= s.s_data;
              r_idx <= r_idx + 3'd1;
              r_len <= w_len_next;
            end
            if (s.s_last) begin
              // A last byte that fills the word leaves no room for the length lane.
              if (w_has_byte && r_idx == 3'd7) begin
                r_pad_pending <= 1'b1;
              end else begin
                core_mi[LEN_LSB +: 8] <= w_len_next;
                r_final_pending       <= 1'b1;
              end
              s.s_ready     <= 1'b0;
              core_compress <= 1'b1;
              r_state       <= ST_COMP;
            end else if (w_has_byte && r_idx == 3'd7) begin
              r_final_pending <= 1'b0;
              s.s_ready       <= 1'b0;
              core_compress   <= 1'b1;
              r_state         <= ST_COMP;
            end
          end
        end
        ST_COMP: begin
          r_state <= ST_CWAIT;
        end
        ST_CWAIT: begin
          if (core_ready) begin
            if (r_pad_pending) begin
              r_state <= ST_PADW;
            end else if (r_final_pending) begin
              core_finalize <= 1'b1;
              r_state       <= ST_FIN;
            end else begin
              core_mi   <= 64'd0;
              r_idx     <= 3'd0;
              s.s_ready <= 1'b1;
              r_state   <= ST_ACC;
            end
          end
        end
        ST_PADW: begin
          core_mi         <= {r_len, 56'd0};
          r_pad_pending   <= 1'b0;
          r_final_pending <= 1'b1;
          core_compress   <= 1'b1;
          r_state         <= ST_COMP;
        end
        ST_FIN: begin
          r_state <= ST_FWAIT;
        end
        ST_FWAIT: begin
          if (core_word_valid && core_ready) begin
            digest       <= core_word;
            digest_valid <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_siphash_msg_feeder.sv
// ============================================================================
// Module : tb_siphash_msg_feeder
// Brief  : Directed bench for siphash_msg_feeder with a behavioural SipHash core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_siphash_msg_feeder;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [127:0] key;
  logic         core_initalize, core_compress, core_finalize, core_long;
  logic [3:0]   core_c, core_d;
  logic [127:0] core_k;
  logic [63:0]  core_mi;
  logic         m_ready, m_valid;
  logic [63:0]  m_word;
  logic [63:0]  digest;
  logic         digest_valid;

  int checks = 0;
  int errors = 0;

  siphash_msg_feeder_if fif ();

  siphash_msg_feeder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .key             (key),
    .s               (fif),
    .core_initalize  (core_initalize),
    .core_compress   (core_compress),
    .core_finalize   (core_finalize),
    .core_long       (core_long),
    .core_c          (core_c),
    .core_d          (core_d),
    .core_k          (core_k),
    .core_mi         (core_mi),
    .core_ready      (m_ready),
    .core_word       (m_word),
    .core_word_valid (m_valid),
    .digest          (digest),
    .digest_valid    (digest_valid)
  );

  always #5 clk = ~clk;

  // ---------------- SipHash reference primitives ----------------
  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic logic [255:0] sip_rounds(input logic [255:0] st, input int n);
    logic [63:0] v0, v1, v2, v3;
    {v3, v2, v1, v0} = st;
    for (int i = 0; i < n; i++) begin
      v0 = v0 + v1; v1 = rotl(v1, 13); v1 = v1 ^ v0; v0 = rotl(v0, 32);
      v2 = v2 + v3; v3 = rotl(v3, 16); v3 = v3 ^ v2;
      v0 = v0 + v3; v3 = rotl(v3, 21); v3 = v3 ^ v0;
      v2 = v2 + v1; v1 = rotl(v1, 17); v1 = v1 ^ v2; v2 = rotl(v2, 32);
    end
    return {v3, v2, v1, v0};
  endfunction

  function automatic logic [255:0] sip_init(input logic [127:0] k);
    return {k[127:64] ^ 64'h7465646279746573, k[63:0] ^ 64'h6c7967656e657261,
            k[127:64] ^ 64'h646f72616e646f6d, k[63:0] ^ 64'h736f6d6570736575};
  endfunction

  function automatic logic [255:0] sip_compress(input logic [255:0] st, input logic [63:0] m, input int c);
    logic [255:0] t;
    t = st;
    t[255:192] = t[255:192] ^ m;
    t = sip_rounds(t, c);
    t[63:0] = t[63:0] ^ m;
    return t;
  endfunction

  function automatic logic [63:0] sip_final(input logic [255:0] st, input int d);
    logic [255:0] t;
    t = st;
    t[191:128] = t[191:128] ^ 64'hff;
    t = sip_rounds(t, d);
    return t[63:0] ^ t[127:64] ^ t[191:128] ^ t[255:192];
  endfunction

  // ---------------- behavioural core ----------------
  logic [255:0] m_v;
  int           m_cnt;
  bit           m_fin;
  logic [63:0]  mi_log[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_word <= 64'd0;
      m_v <= '0; m_cnt <= 0; m_fin <= 1'b0;
    end else if (core_initalize) begin
      m_v <= sip_init(core_k);
      m_valid <= 1'b0;
    end else if (core_compress) begin
      m_v <= sip_compress(m_v, core_mi, int'(core_c));
      mi_log.push_back(core_mi);
      m_ready <= 1'b0; m_cnt <= $urandom_range(1, 3); m_fin <= 1'b0;
    end else if (core_finalize) begin
      m_ready <= 1'b0; m_valid <= 1'b0; m_cnt <= $urandom_range(1, 3); m_fin <= 1'b1;
    end else if (!m_ready) begin
      if (m_cnt <= 1) begin
        m_ready <= 1'b1;
        if (m_fin) begin
          m_valid <= 1'b1;
          m_word  <= sip_final(m_v, int'(core_d));
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // ---------------- pulse / stall monitor ----------------
  logic [2:0] mon_p;
  logic [2:0] mon_prev = 3'd0;

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_prev = 3'd0;
    end else begin
      mon_p = {core_initalize, core_compress, core_finalize};
      checks += 3;
      if ($countones(mon_p) > 1) begin
        errors++; $display("FAIL pulse_overlap: got %b required at most one bit set", mon_p);
      end
      if ((mon_p & mon_prev) != 3'd0) begin
        errors++; $display("FAIL pulse_width: got %b after %b required single-cycle pulses", mon_p, mon_prev);
      end
      if (fif.s_ready && (core_compress || !m_ready)) begin
        errors++; $display("FAIL ready_stall: got s_ready=1 required 0 while core busy");
      end
      mon_prev = mon_p;
    end
  end

  // ---------------- host driver ----------------
  logic [7:0] msg [300];

  task automatic xfer(input logic [7:0] d, input bit last, input bit empty, output bit ok);
    int b = 0;
    fif.s_valid = 1'b1; fif.s_data = d; fif.s_last = last; fif.s_empty = empty;
    while (!fif.s_ready && b < 500) begin
      @(negedge clk); b++;
    end
    ok = fif.s_ready;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: got s_ready=0 required 1 within 500 cycles");
    end
    @(negedge clk);
    fif.s_valid = 1'b0; fif.s_last = 1'b0; fif.s_empty = 1'b0;
  endtask

  task automatic send_msg(input int n, input bit gaps);
    bit ok;
    mi_log.delete();
    if (n == 0) begin
      xfer(8'h00, 1'b1, 1'b1, ok);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        xfer(msg[i], i == n - 1, 1'b0, ok);
        if (!ok) break;
      end
    end
    checks++;
    if (digest_valid !== 1'b0) begin
      errors++; $display("FAIL dv_clear: got digest_valid=%b required 0", digest_valid);
    end
  endtask

  task automatic wait_digest(input logic [63:0] exp, input string name);
    int b = 0;
    while (!digest_valid && b < 500) begin
      @(negedge clk); b++;
    end
    checks++;
    if (digest_valid !== 1'b1) begin
      errors++; $display("FAIL %s_timeout: got digest_valid=%b required 1", name, digest_valid);
    end else if (digest !== exp) begin
      errors++; $display("FAIL %s: got %h required %h", name, digest, exp);
    end
  endtask

  function automatic logic [63:0] ref_siphash(input logic [127:0] k, input int n);
    logic [255:0] st;
    logic [63:0]  m;
    st = sip_init(k);
    for (int w = 0; w < n / 8; w++) begin
      for (int j = 0; j < 8; j++) m[8*j +: 8] = msg[8*w + j];
      st = sip_compress(st, m, 2);
    end
    m = '0;
    for (int j = 0; j < n % 8; j++) m[8*j +: 8] = msg[8*(n/8) + j];
    m[63:56] = n[7:0];
    st = sip_compress(st, m, 2);
    return sip_final(st, 4);
  endfunction

  // ---------------- tests ----------------
  task automatic check_idle_outputs(input string name);
    checks++;
    if (fif.s_ready !== 1'b0 || digest_valid !== 1'b0 || core_mi !== 64'd0 ||
        core_k !== 128'd0 || digest !== 64'd0 ||
        {core_initalize, core_compress, core_finalize} !== 3'b000) begin
      errors++;
      $display("FAIL %s: got rdy=%b dv=%b mi=%h k=%h dig=%h pulses=%b required all 0",
               name, fif.s_ready, digest_valid, core_mi, core_k, digest,
               {core_initalize, core_compress, core_finalize});
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_release");
    checks++;
    if (core_c !== 4'd2 || core_d !== 4'd4 || core_long !== 1'b0) begin
      errors++; $display("FAIL rounds: got c=%0d d=%0d long=%b required 2 4 0", core_c, core_d, core_long);
    end
  endtask

  task automatic test_empty();
    send_msg(0, 1'b0);
    wait_digest(64'h726fdb47dd0e0e31, "empty_digest");
    checks++;
    if (mi_log.size() != 1 || mi_log[0] !== 64'd0) begin
      errors++; $display("FAIL empty_words: got count=%0d first=%h required 1 0", mi_log.size(), mi_log[0]);
    end
  endtask

  task automatic test_15_bytes();
    for (int i = 0; i < 15; i++) msg[i] = 8'(i);
    send_msg(15, 1'b0);
    wait_digest(64'ha129ca6149be45e5, "b15_digest");
    checks++;
    if (mi_log.size() != 2) begin
      errors++; $display("FAIL b15_count: got %0d required 2", mi_log.size());
    end
    checks++;
    if (mi_log[0] !== 64'h0706050403020100) begin
      errors++; $display("FAIL b15_word0: got %h required 0706050403020100", mi_log[0]);
    end
    checks++;
    if (mi_log[1] !== 64'h0f0e0d0c0b0a0908) begin
      errors++; $display("FAIL b15_word1: got %h required 0f0e0d0c0b0a0908", mi_log[1]);
    end
  endtask

  task automatic test_back_to_back_8();
    for (int i = 0; i < 8; i++) msg[i] = 8'(i);
    send_msg(8, 1'b0);
    wait_digest(64'h93f5f5799a932462, "b8_digest");
    checks++;
    if (mi_log.size() != 2 || mi_log[0] !== 64'h0706050403020100 || mi_log[1] !== 64'h0800000000000000) begin
      errors++; $display("FAIL b8_words: got count=%0d %h %h required 2 0706050403020100 0800000000000000",
                         mi_log.size(), mi_log[0], mi_log[1]);
    end
  endtask

  task automatic test_gaps_300();
    logic [63:0] exp;
    for (int i = 0; i < 300; i++) msg[i] = 8'($urandom);
    exp = ref_siphash(key, 300);
    send_msg(300, 1'b1);
    wait_digest(exp, "b300_digest");
    checks++;
    if (mi_log.size() != 38) begin
      errors++; $display("FAIL b300_count: got %0d required 38", mi_log.size());
    end else begin
      checks++;
      if (mi_log[37][63:56] !== 8'h2c) begin
        errors++; $display("FAIL b300_pad: got %h required 2c", mi_log[37][63:56]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int i = 0; i < 15; i++) msg[i] = 8'(i);
    mi_log.delete();
    for (int i = 0; i < 8; i++) xfer(msg[i], 1'b0, 1'b0, ok);
    checks++;
    if (core_compress !== 1'b1) begin
      errors++; $display("FAIL mid_comp: got core_compress=%b required 1", core_compress);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_msg(15, 1'b0);
    wait_digest(64'ha129ca6149be45e5, "after_reset_digest");
  endtask

  initial begin
    fif.s_valid = 1'b0; fif.s_data = 8'h00; fif.s_last = 1'b0; fif.s_empty = 1'b0;
    key = 128'h0f0e0d0c0b0a09080706050403020100;
    @(negedge clk);
    test_reset();
    test_empty();
    test_15_bytes();
    test_back_to_back_8();
    test_gaps_300();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/siphash_msg_feeder.md
Name: siphash_msg_feeder

Overview:
- Initiator/driver for siphash_core: accepts a byte stream with valid/ready handshake and packs bytes little-endian into 64-bit message words.
- Generates SipHash final padding (length mod 256 in the top byte) and sequences the core's initalize/compress/finalize controls.
- Captures the 64-bit digest and presents it to the host; sits between a host byte source and one siphash_core instance.

Parameters:
C_ROUNDS, 4'd2, compression rounds driven on core_c
D_ROUNDS, 4'd4, finalization rounds driven on core_d

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
key  input  128  key; k0 = key[63:0]; sampled when a message starts
s_valid  input  1  byte valid
s_ready  output  1  byte accepted when s_valid && s_ready
s_data  input  8  message byte, earliest byte first
s_last  input  1  marks final transfer of the message
s_empty  input  1  with s_last: transfer carries no byte (zero-length message); ignored otherwise
core_initalize  output  1  one-cycle pulse to core
core_compress  output  1  one-cycle pulse to core
core_finalize  output  1  one-cycle pulse to core
core_long  output  1  tied 0
core_c  output  4  C_ROUNDS
core_d  output  4  D_ROUNDS
core_k  output  128  registered key
core_mi  output  64  registered message word
core_ready  input  1  core ready
core_word  input  64  core siphash_word[63:0]
core_word_valid  input  1  core digest valid
digest  output  64  captured digest
digest_valid  output  1  high from capture until next message start

Behaviour:
- Clocking and reset: single clock. Async active-low reset puts every output and register at 0 (s_ready=0, digest_valid=0, core_mi=0, core_k=0) and forces state IDLE.
- Control pulses: all core controls are registered, one cycle wide, at most one asserted per cycle.
- FSM states: IDLE, INIT, ACC, COMP, CWAIT, PADW, FIN, FWAIT.
- IDLE: s_ready=0. When s_valid && core_ready: latch key into core_k, clear byte index (3b) and length counter (8b), clear digest_valid -> INIT.
- INIT: pulse core_initalize; clear core_mi -> ACC. The core completes initalize in that same cycle and keeps ready high.
- ACC: s_ready=1.
  - Byte accepted (not empty): write core_mi byte lane [idx*8+:8], idx++, len++ (wraps at 256).
  - Non-last byte with idx==7 -> COMP, with final_pending=0.
  - Last transfer, resulting idx 1..7 or empty (idx 0) -> write lane 7 = updated len, final_pending=1 -> COMP.
  - Last byte filling idx==7 (word full) -> COMP with pad_pending=1.
- COMP: s_ready=0; pulse core_compress -> CWAIT.
- CWAIT: wait for core_ready==1 (ready is already 0 in the first CWAIT cycle). Then:
  - pad_pending -> PADW;
  - else final_pending -> FIN;
  - else clear core_mi, idx=0 -> ACC.
- PADW: core_mi = {len,56'h0}; pad_pending=0, final_pending=1 -> COMP.
- FIN: pulse core_finalize -> FWAIT.
- FWAIT: on core_word_valid && core_ready, capture digest=core_word and set digest_valid=1 -> IDLE.
- Length: byte count mod 256; a 256-byte message pads with 0x00.
- Word count: a message of n bytes issues floor(n/8)+1 compress operations.
- Mid-message reset: discards everything; the core must share the reset.
- s_last with s_empty after bytes have already been accepted: treat as end-of-message with no new byte.

Decomposition:
- Shared package siphash_pkg: SipHash IV constants, default C/D round counts, feeder state encodings (3-bit), padding length-lane index (7).
- No sub-module: the byte packer is inline (lane write plus counter).
- Test harness instantiates siphash_core alongside.

Test Plan:
- Key 00..0f, empty message (single s_last+s_empty) -> one compress with mi=64'h0, digest 64'h726fdb47dd0e0e31, digest_valid=1.
- Key 00..0f, bytes 00..0e (15) -> two compresses (second mi=64'h0f0e0d0c0b0a0908), digest 64'ha129ca6149be45e5.
- Key 00..0f, bytes 00..07 -> mi words 64'h0706050403020100 then 64'h0800000000000000, digest 64'h93f5f5799a932462.
- Random s_valid gaps and 300-byte message -> s_ready low during every COMP/CWAIT, no byte lost, pad byte 0x2c, digest matches software model.
- reset_n asserted in CWAIT mid-message -> all outputs 0 next cycle; a fresh 15-byte message then yields 64'ha129ca6149be45e5.
- Check each control pulse is exactly one cycle wide and never overlaps another.
